// File: rtl/bomb_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : bomb_scheduler_if
//  Purpose  : Bundles the bomb placement request/response channel, the
//             per-slot status bus and the explosion valid/ready stream.
//  Modports : master - the side that drives place_req/b_x/b_y/exp_ready
//             slave  - the bomb scheduler that answers and drives the rest
//  Revision : 1.0  initial release
// ============================================================================
interface bomb_scheduler_if #(
    parameter int NUM_SLOTS = 4
);
    logic                     place_req;
    logic [9:0]               b_x;
    logic [9:0]               b_y;
    logic                     place_ack;
    logic                     place_nack;
    logic [NUM_SLOTS-1:0]     slot_active;
    logic [10*NUM_SLOTS-1:0]  slot_x;
    logic [10*NUM_SLOTS-1:0]  slot_y;
    logic [3:0]               active_count;
    logic                     exp_valid;
    logic                     exp_ready;
    logic [9:0]               exp_x;
    logic [9:0]               exp_y;

    modport master (
        output place_req, b_x, b_y, exp_ready,
        input  place_ack, place_nack, slot_active, slot_x, slot_y,
               active_count, exp_valid, exp_x, exp_y
    );

    modport slave (
        input  place_req, b_x, b_y, exp_ready,
        output place_ack, place_nack, slot_active, slot_x, slot_y,
               active_count, exp_valid, exp_x, exp_y
    );
endinterface
`default_nettype wire

// File: rtl/bomb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : bomb_scheduler
//  Purpose  : Bomb slot table for the player. Detects button presses,
//             allocates the lowest free slot, runs each bomb's fuse and
//             queues detonations into an explosion FIFO.
//  Ports    : clk      - system clock
//             reset_n  - asynchronous active-low reset
//             bus      - bomb_scheduler_if.slave (request/ack, slot bus,
//                        explosion valid/ready stream)
//  Revision : 1.0  initial release
// ============================================================================
module bomb_scheduler #(
    parameter int NUM_SLOTS   = 4,
    parameter int FUSE_CYCLES = 400000000,
    parameter int CNT_W       = 29
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    bomb_scheduler_if.slave    bus
);
    localparam int PTR_W = $clog2(NUM_SLOTS);
    localparam int FCNT_W = $clog2(NUM_SLOTS + 1);
    localparam logic [CNT_W-1:0] c_fuse_last = CNT_W'(FUSE_CYCLES - 1);

    // Slot table
    logic [NUM_SLOTS-1:0] r_active;
    logic [9:0]           r_x   [NUM_SLOTS];
    logic [9:0]           r_y   [NUM_SLOTS];
    logic [CNT_W-1:0]     r_cnt [NUM_SLOTS];
    logic [3:0]           r_active_count;

    // Button sample and previous sample
    logic r_req_s;
    logic r_req_p;
    logic r_ack;
    logic r_nack;

    // Explosion FIFO
    logic [9:0]        r_fx [NUM_SLOTS];
    logic [9:0]        r_fy [NUM_SLOTS];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [FCNT_W-1:0] r_fcount;

    logic                 w_req;
    logic                 w_pop;
    logic                 w_can_push;
    logic                 w_exp_valid;
    logic                 w_dup;
    logic                 w_has_free;
    logic [PTR_W-1:0]     w_free_idx;
    logic                 w_any_exp;
    logic [PTR_W-1:0]     w_exp_idx;
    logic                 w_place;
    logic                 w_push;
    logic [NUM_SLOTS-1:0] w_active_next;
    logic [3:0]           w_active_count_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_SLOTS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_req       = r_req_s & ~r_req_p;
    assign w_exp_valid = (r_fcount != '0);
    assign w_pop       = w_exp_valid & bus.exp_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_can_push  = (r_fcount != FCNT_W'(NUM_SLOTS)) | w_pop;

    always_comb begin
        w_dup      = 1'b0;
        w_has_free = 1'b0;
        w_free_idx = '0;
        w_any_exp  = 1'b0;
        w_exp_idx  = '0;
        // Descending scan so the lowest matching index is the one kept.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (r_active[i] && (r_x[i] == bus.b_x) && (r_y[i] == bus.b_y))
                w_dup = 1'b1;
            // An expiring slot is still armed, so it never looks free here.
            if (!r_active[i]) begin
                w_has_free = 1'b1;
                w_free_idx = PTR_W'(i);
            end
            if (r_active[i] && (r_cnt[i] == c_fuse_last)) begin
                w_any_exp = 1'b1;
                w_exp_idx = PTR_W'(i);
            end
        end
        w_place = w_req & ~w_dup & w_has_free;
        w_push  = w_any_exp & w_can_push;

        w_active_next = r_active;
        if (w_push)
            w_active_next[w_exp_idx] = 1'b0;
        if (w_place)
            w_active_next[w_free_idx] = 1'b1;

        w_active_count_next = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            w_active_count_next = w_active_count_next + 4'(w_active_next[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req_s        <= 1'b0;
            r_req_p        <= 1'b0;
            r_ack          <= 1'b0;
            r_nack         <= 1'b0;
            r_active       <= '0;
            r_active_count <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_fcount       <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_x[i]   <= '0;
                r_y[i]   <= '0;
                r_cnt[i] <= '0;
                r_fx[i]  <= '0;
                r_fy[i]  <= '0;
            end
        end else begin
            r_req_s        <= bus.place_req;
            r_req_p        <= r_req_s;
            r_ack          <= w_place;
            r_nack         <= w_req & ~w_place;
            r_active       <= w_active_next;
            r_active_count <= w_active_count_next;

            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_place && (w_free_idx == PTR_W'(i))) begin
                    r_x[i]   <= bus.b_x;
                    r_y[i]   <= bus.b_y;
                    r_cnt[i] <= '0;
                end else if (r_active[i]) begin
                    // At the terminal count the slot holds until its push wins.
                    if (r_cnt[i] != c_fuse_last)
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    else if (w_push && (w_exp_idx == PTR_W'(i)))
                        r_cnt[i] <= '0;
                end
            end

            if (w_push) begin
                r_fx[r_wr_ptr] <= r_x[w_exp_idx];
                r_fy[r_wr_ptr] <= r_y[w_exp_idx];
                r_wr_ptr       <= ptr_inc(r_wr_ptr);
            end
            if (w_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_fcount <= r_fcount + FCNT_W'(w_push) - FCNT_W'(w_pop);
        end
    end

    assign bus.place_ack    = r_ack;
    assign bus.place_nack   = r_nack;
    assign bus.slot_active  = r_active;
    assign bus.active_count = r_active_count;
    assign bus.exp_valid    = w_exp_valid;
    assign bus.exp_x        = w_exp_valid ? r_fx[r_rd_ptr] : '0;
    assign bus.exp_y        = w_exp_valid ? r_fy[r_rd_ptr] : '0;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
        assign bus.slot_x[10*g +: 10] = r_x[g];
        assign bus.slot_y[10*g +: 10] = r_y[g];
    end
endmodule
`default_nettype wire
